// File: rtl/aska_spi_master.sv
// SPI master that ships one 40-bit frame {6'b0, addr, data} per start request.
// SPI mode 0, MSB first, with SPI_Clk half-period set by CLK_DIV clk cycles.
module aska_spi_master #(
    parameter int CLK_DIV = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  addr,
    input  logic [31:0] data,
    output logic        busy,
    output logic        done,
    output logic        SPI_CS,
    output logic        SPI_Clk,
    output logic        SPI_MOSI
);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [5:0] LAST_BIT = 6'd39;

    state_t      state_q, state_d;
    logic [7:0]  div_q, div_d;
    logic [5:0]  bit_q, bit_d;
    logic [39:0] frame_q, frame_d;
    logic        cs_q, cs_d;
    logic        sclk_q, sclk_d;
    logic        mosi_q, mosi_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [39:0] new_frame;

    assign new_frame = {6'b000000, addr, data};

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        frame_d = frame_q;
        cs_d    = cs_q;
        sclk_d  = sclk_q;
        mosi_d  = mosi_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                // A start coinciding with the done pulse is dropped on purpose.
                if (start && !done_q) begin
                    state_d = SETUP;
                    frame_d = new_frame;
                    div_d   = DIV_LAST;
                    bit_d   = 6'd0;
                    cs_d    = 1'b0;
                    sclk_d  = 1'b0;
                    mosi_d  = new_frame[39];
                    busy_d  = 1'b1;
                end
            end
            SETUP: begin
                if (div_q == 8'd0) begin
                    state_d = SHIFT;
                    div_d   = DIV_LAST;
                    sclk_d  = 1'b1;
                end else begin
                    div_d = div_q - 8'd1;
                end
            end
            SHIFT: begin
                if (div_q != 8'd0) begin
                    div_d = div_q - 8'd1;
                end else begin
                    div_d = DIV_LAST;
                    if (sclk_q) begin
                        // Next bit goes out together with the falling edge.
                        sclk_d = 1'b0;
                        if (bit_q != LAST_BIT) begin
                            mosi_d = frame_q[6'd38 - bit_q];
                        end
                    end else if (bit_q == LAST_BIT) begin
                        state_d = HOLD;
                    end else begin
                        bit_d  = bit_q + 6'd1;
                        sclk_d = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (div_q == 8'd0) begin
                    state_d = GAP;
                    div_d   = DIV_LAST;
                    cs_d    = 1'b1;
                    mosi_d  = 1'b0;
                end else begin
                    div_d = div_q - 8'd1;
                end
            end
            GAP: begin
                if (div_q == 8'd0) begin
                    state_d = IDLE;
                    div_d   = 8'd0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    div_d = div_q - 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            div_q   <= 8'd0;
            bit_q   <= 6'd0;
            frame_q <= 40'd0;
            cs_q    <= 1'b1;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            frame_q <= frame_d;
            cs_q    <= cs_d;
            sclk_q  <= sclk_d;
            mosi_q  <= mosi_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign SPI_CS   = cs_q;
    assign SPI_Clk  = sclk_q;
    assign SPI_MOSI = mosi_q;

endmodule

// File: tb/tb_aska_spi_master.sv
// Bench for aska_spi_master: timeline model per frame, a slave register model
// and SPI protocol checks, driving one CLK_DIV=4 and one CLK_DIV=2 instance.
module tb_aska_spi_master;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start4 = 1'b0, start2 = 1'b0;
    logic [1:0]  addr4 = 2'd0, addr2 = 2'd0;
    logic [31:0] data4 = 32'd0, data2 = 32'd0;
    logic        busy4, done4, cs4, sclk4, mosi4;
    logic        busy2, done2, cs2, sclk2, mosi2;

    always #5 clk = ~clk;

    aska_spi_master #(.CLK_DIV(4)) u_dut4 (
        .clk(clk), .reset(reset), .start(start4), .addr(addr4), .data(data4),
        .busy(busy4), .done(done4), .SPI_CS(cs4), .SPI_Clk(sclk4), .SPI_MOSI(mosi4)
    );

    aska_spi_master #(.CLK_DIV(2)) u_dut2 (
        .clk(clk), .reset(reset), .start(start2), .addr(addr2), .data(data2),
        .busy(busy2), .done(done2), .SPI_CS(cs2), .SPI_Clk(sclk2), .SPI_MOSI(mosi2)
    );

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;
    int start_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Expected {SPI_CS, SPI_Clk, SPI_MOSI, busy, done} at cycle k of a frame.
    function automatic logic [4:0] expOut(input int d, input bit act, input int k, input logic [39:0] f);
        int j, b, ph;
        if (!act) return 5'b10000;
        if (k == 83 * d) return 5'b10001;
        if (k < d) return {2'b00, f[39], 2'b10};
        if (k < 81 * d) begin
            j  = k - d;
            b  = j / (2 * d);
            ph = j % (2 * d);
            if (ph < d) return {2'b01, f[39 - b], 2'b10};
            return {2'b00, (b < 39) ? f[38 - b] : f[0], 2'b10};
        end
        if (k < 82 * d) return {2'b00, f[0], 2'b10};
        return 5'b10010;
    endfunction

    bit          m4_act = 0, m2_act = 0;
    int          m4_k = 0, m2_k = 0;
    logic [39:0] m4_f = '0, m2_f = '0;
    bit          seen_reset = 0;
    bit          rst_now;

    logic [39:0] sh4 = '0, last_frame4 = '0;
    int          rise4 = 0;
    int          done4_cnt = 0;
    logic [31:0] slave_reg [4] = '{default: 32'd0};
    logic        prev_sclk4 = 1'b0, prev_cs4 = 1'b1, prev_mosi4 = 1'b0;

    // Single compare process: advance the models at the edge, check #1 later.
    always @(posedge clk) begin
        rst_now = reset;
        if (rst_now) begin
            m4_act = 0; m4_k = 0;
            m2_act = 0; m2_k = 0;
        end else begin
            if (m4_act) begin
                if (m4_k == 83 * 4) m4_act = 0; else m4_k++;
            end else if (start4) begin
                m4_act = 1; m4_k = 0; m4_f = {6'b000000, addr4, data4};
            end
            if (m2_act) begin
                if (m2_k == 83 * 2) m2_act = 0; else m2_k++;
            end else if (start2) begin
                m2_act = 1; m2_k = 0; m2_f = {6'b000000, addr2, data2};
            end
        end
        #1;
        if (seen_reset) begin
            checkOutput("dut4 outputs", {cs4, sclk4, mosi4, busy4, done4}, expOut(4, m4_act, m4_k, m4_f));
            checkOutput("dut2 outputs", {cs2, sclk2, mosi2, busy2, done2}, expOut(2, m2_act, m2_k, m2_f));
            if (cs4) checkOutput("sclk low while cs high", sclk4, 1'b0);
            if (sclk4 && prev_sclk4) checkOutput("mosi stable while sclk high", mosi4, prev_mosi4);
            if (!cs4 && sclk4 && !prev_sclk4) begin
                sh4 = {sh4[38:0], mosi4};
                rise4++;
            end
            if (cs4 && !prev_cs4) begin
                if (!rst_now) begin
                    checkOutput("rising edges per cs window", 64'(rise4), 64'd40);
                    if (rise4 == 40) slave_reg[sh4[33:32]] = sh4[31:0];
                    last_frame4 = sh4;
                end
                rise4 = 0;
                sh4 = '0;
            end
            if (done4) done4_cnt++;
        end
        if (rst_now) seen_reset = 1;
        prev_sclk4 = sclk4;
        prev_cs4   = cs4;
        prev_mosi4 = mosi4;
    end

    // One-cycle start pulse on the selected instance.
    task automatic applyStimulus(input int which, input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        if (which == 4) begin start4 = 1'b1; addr4 = a; data4 = d; end
        else begin start2 = 1'b1; addr2 = a; data2 = d; end
        start_cyc = cyc;
        @(negedge clk);
        start4 = 1'b0;
        start2 = 1'b0;
    endtask

    task automatic waitDone(input int which, output int lat);
        bit ok;
        ok = 0;
        lat = 0;
        for (int n = 0; n < 2000; n++) begin
            @(posedge clk);
            #1;
            if ((which == 4) ? done4 : done2) begin
                ok = 1;
                lat = cyc - start_cyc;
                break;
            end
        end
        if (!ok) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL done wait timeout: got no done, expected done within 2000 cycles");
        end
    endtask

    int lat;
    logic [31:0] b2b_data [4] = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};

    initial begin
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("reset state", {cs4, sclk4, mosi4, busy4, done4}, 5'b10000);

        // Single ele1 write, with latency and slave view pinned to literals.
        applyStimulus(4, 2'b10, 32'hDEADBEEF);
        waitDone(4, lat);
        checkOutput("latency div4", 64'(lat), 64'd333);
        checkOutput("shifted frame", last_frame4, 40'h02DEADBEEF);
        checkOutput("slave ele1", slave_reg[2], 32'hDEADBEEF);

        // Back-to-back: start held through the done cycle and the one after.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            start4 = 1'b1;
            addr4 = 2'(i);
            data4 = b2b_data[i];
            @(negedge clk);
            @(negedge clk);
            start4 = 1'b0;
            waitDone(4, lat);
        end
        repeat (5) @(negedge clk);
        checkOutput("slave conf0", slave_reg[0], 32'h11111111);
        checkOutput("slave conf1", slave_reg[1], 32'h22222222);
        checkOutput("slave ele1 b2b", slave_reg[2], 32'h33333333);
        checkOutput("slave ele2", slave_reg[3], 32'h44444444);
        checkOutput("done count b2b", 64'(done4_cnt), 64'd5);

        // Start requests mid-frame with changed addr/data must be ignored.
        applyStimulus(4, 2'b00, 32'hA5A5A5A5);
        repeat (9) @(negedge clk);
        start4 = 1'b1; addr4 = 2'b01; data4 = 32'hFFFFFFFF;
        @(negedge clk);
        start4 = 1'b0;
        repeat (89) @(negedge clk);
        start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        waitDone(4, lat);
        repeat (5) @(negedge clk);
        checkOutput("slave conf0 busy-start", slave_reg[0], 32'hA5A5A5A5);
        checkOutput("slave conf1 untouched", slave_reg[1], 32'h22222222);
        checkOutput("done count busy-start", 64'(done4_cnt), 64'd6);

        // Reset after 20 rising SPI_Clk edges truncates the frame.
        applyStimulus(4, 2'b11, 32'h99999999);
        for (int n = 0; n < 2000; n++) begin
            if (rise4 >= 20) break;
            @(negedge clk);
        end
        checkOutput("rising edges before reset", 64'(rise4), 64'd20);
        reset = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("cs after abort", cs4, 1'b1);
        checkOutput("busy after abort", busy4, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        repeat (400) @(negedge clk);
        checkOutput("done count after abort", 64'(done4_cnt), 64'd6);
        checkOutput("slave ele2 after abort", slave_reg[3], 32'h44444444);

        // Reset wins over start in the same cycle.
        @(negedge clk);
        reset = 1'b1;
        start4 = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("reset over start busy", busy4, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        start4 = 1'b0;

        // Fastest divider instance.
        applyStimulus(2, 2'b01, 32'h12345678);
        waitDone(2, lat);
        checkOutput("latency div2", 64'(lat), 64'd167);

        repeat (5) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/aska_spi_master.md
ASKA_SPI_MASTER -- requirements
Module: aska_spi_master

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4, meaning SPI_Clk half-period in clk cycles; legal range 2..255.
REQ-002 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request to send one frame; sampled each clk.
REQ-005 SHALL have port addr  input  2  target register select: 00 conf0, 01 conf1, 10 ele1, 11 ele2.
REQ-006 SHALL have port data  input  32  register payload.
REQ-007 SHALL have port busy  output  1  frame in progress; start ignored while high.
REQ-008 SHALL have port done  output  1  one-cycle pulse at frame completion.
REQ-009 SHALL have port SPI_CS  output  1  chip select, active low.
REQ-010 SHALL have port SPI_Clk  output  1  SPI clock, mode 0 (idle low).
REQ-011 SHALL have port SPI_MOSI  output  1  serial data to slave.

Function
REQ-012 SHALL implement states IDLE, SETUP, SHIFT, HOLD, GAP.
REQ-013 In IDLE with start=1, SHALL latch frame = {6'b000000, addr, data} (40 bits) and enter SETUP; busy=1 and SPI_CS=0 from the next cycle.
REQ-014 SHALL transmit frame MSB first (bit 39 first, bit 0 last), so addr lands in slave bits 33:32 and data in 31:0.
REQ-015 SETUP: SPI_CS=0, SPI_Clk=0, SPI_MOSI=bit 39, held CLK_DIV cycles, then SHIFT.
REQ-016 SHIFT: per bit, SPI_Clk high CLK_DIV cycles then low CLK_DIV cycles; SPI_MOSI changes only on the clk cycle SPI_Clk goes low, never while SPI_Clk high.
REQ-017 SHIFT SHALL produce exactly 40 SPI_Clk rising edges; a 6-bit bit counter tracks 0..39, enters HOLD after falling edge of bit 39.
REQ-018 HOLD: SPI_CS=0, SPI_Clk=0, CLK_DIV cycles, then GAP with SPI_CS=1.
REQ-019 GAP: SPI_CS=1, SPI_Clk=0, SPI_MOSI=0, CLK_DIV cycles (minimum CS-high time).
REQ-020 After GAP, done=1 for exactly one cycle, busy=0 that same cycle, state IDLE.
REQ-021 Start-to-done latency SHALL be 1 + 83*CLK_DIV clk cycles (333 for CLK_DIV=4).
REQ-022 start asserted while busy=1 SHALL be ignored, not queued; frame latch SHALL not change mid-frame when addr/data inputs change.
REQ-023 start asserted in the done cycle SHALL be ignored; start in the following cycle SHALL be accepted (back-to-back frames).
REQ-024 All outputs SHALL be registered; no glitches on SPI_CS, SPI_Clk, SPI_MOSI.
REQ-025 Divider counter SHALL be 8 bits and reload on every phase change; no wrap-around in any state.

Reset
REQ-026 On reset=1 at a clk edge: state IDLE, SPI_CS=1, SPI_Clk=0, SPI_MOSI=0, busy=0, done=0, frame latch 0, counters 0.
REQ-027 Reset mid-frame SHALL raise SPI_CS within one cycle without further SPI_Clk edges; resulting truncated frame (fewer than 40 bits) is discarded by the slave; no done pulse.
REQ-028 reset SHALL take priority over start in the same cycle.

Verification
REQ-029 CLK_DIV=4, start with addr=10, data=0xDEADBEEF -> MOSI over 40 rising edges reads 0x02DEADBEEF; done at cycle 333; slave model ele1=0xDEADBEEF.
REQ-030 Four back-to-back frames addr 00..11, data 0x11111111..0x44444444 -> slave conf0/conf1/ele1/ele2 hold respective values; exactly four done pulses.
REQ-031 start pulsed at cycles 10 and 100 of an active frame -> ignored; only one done; slave register unchanged by second request.
REQ-032 reset asserted after 20 SPI_Clk rising edges -> SPI_CS=1 next cycle, busy=0, no done; slave registers unchanged.
REQ-033 CLK_DIV=2 -> SPI_Clk high/low 2 cycles each, latency 167 cycles, MOSI stable at every rising edge.
REQ-034 Protocol checker throughout: SPI_Clk low whenever SPI_CS=1; exactly 40 rising edges per CS-low window; MOSI never toggles while SPI_Clk high.
